// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : ID/EX pipeline register feeding the 32-bit MIPS ALU.
//                Decodes ALUOp/funct into the 4-bit ALU control code,
//                selects register or extended immediate for operand B,
//                and registers everything for one cycle. Supports stall
//                (hold) and flush (bubble).
//                Optional macro FORWARDING_EN adds EX/MEM and MEM/WB
//                operand forwarding ahead of the pipeline register.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int W      = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              alu_src,
    input  logic [W-1:0]      rs_data,
    input  logic [W-1:0]      rt_data,
    input  logic [15:0]       imm16,
    input  logic [REG_AW-1:0] rd_in,
    input  logic              reg_write_in,
`ifdef FORWARDING_EN
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              exmem_we,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [W-1:0]      exmem_data,
    input  logic              memwb_we,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [W-1:0]      memwb_data,
`endif
    output logic              ex_valid,
    output logic [3:0]        alu_ctl,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [W-1:0]      rt_data_out,
    output logic [REG_AW-1:0] rd_out,
    output logic              reg_write_out,
    output logic              illegal_funct
);

    // ALUOp encodings from the main decoder
    localparam logic [1:0] c_OP_ADD   = 2'b00;
    localparam logic [1:0] c_OP_SUB   = 2'b01;
    localparam logic [1:0] c_OP_RTYPE = 2'b10;
    localparam logic [1:0] c_OP_OR    = 2'b11;

    // R-type function codes understood by the ALU
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    // ALU control codes
    localparam logic [3:0] c_CTL_AND = 4'h0;
    localparam logic [3:0] c_CTL_OR  = 4'h1;
    localparam logic [3:0] c_CTL_ADD = 4'h2;
    localparam logic [3:0] c_CTL_SUB = 4'h6;
    localparam logic [3:0] c_CTL_SLT = 4'h7;
    localparam logic [3:0] c_CTL_BAD = 4'hF;

    logic [3:0]        w_alu_ctl;
    logic              w_illegal;
    logic [W-1:0]      w_ext_imm;
    logic [W-1:0]      w_rs_val;
    logic [W-1:0]      w_rt_val;
    logic [W-1:0]      w_alu_b;

    logic              r_ex_valid;
    logic [3:0]        r_alu_ctl;
    logic [W-1:0]      r_alu_a;
    logic [W-1:0]      r_alu_b;
    logic [W-1:0]      r_rt_data;
    logic [REG_AW-1:0] r_rd;
    logic              r_reg_write;
    logic              r_illegal;

    // ALU control decode; unknown R-type funct flags an illegal instruction
    always_comb begin
        w_alu_ctl = c_CTL_ADD;
        w_illegal = 1'b0;
        case (alu_op)
            c_OP_ADD: w_alu_ctl = c_CTL_ADD;
            c_OP_SUB: w_alu_ctl = c_CTL_SUB;
            c_OP_OR:  w_alu_ctl = c_CTL_OR;
            c_OP_RTYPE: begin
                case (funct)
                    c_FN_ADD: w_alu_ctl = c_CTL_ADD;
                    c_FN_SUB: w_alu_ctl = c_CTL_SUB;
                    c_FN_AND: w_alu_ctl = c_CTL_AND;
                    c_FN_OR:  w_alu_ctl = c_CTL_OR;
                    c_FN_SLT: w_alu_ctl = c_CTL_SLT;
                    default: begin
                        w_alu_ctl = c_CTL_BAD;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            default: w_alu_ctl = c_CTL_ADD;
        endcase
    end

    // Logical ori zero-extends; arithmetic and address ops sign-extend
    always_comb begin
        if (alu_op == c_OP_OR) begin
            w_ext_imm = {{(W-16){1'b0}}, imm16};
        end else begin
            w_ext_imm = {{(W-16){imm16[15]}}, imm16};
        end
    end

`ifdef FORWARDING_EN
    // Operand forwarding: MEM/WB applied first so the younger EX/MEM result overrides it
    always_comb begin
        w_rs_val = rs_data;
        w_rt_val = rt_data;
        if (memwb_we && (memwb_rd != '0) && (memwb_rd == rs_addr)) begin
            w_rs_val = memwb_data;
        end
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == rs_addr)) begin
            w_rs_val = exmem_data;
        end
        if (memwb_we && (memwb_rd != '0) && (memwb_rd == rt_addr)) begin
            w_rt_val = memwb_data;
        end
        if (exmem_we && (exmem_rd != '0) && (exmem_rd == rt_addr)) begin
            w_rt_val = exmem_data;
        end
    end
`else
    // Without forwarding the register-file values pass straight through
    always_comb begin
        w_rs_val = rs_data;
        w_rt_val = rt_data;
    end
`endif

    // Operand B source select
    always_comb begin
        w_alu_b = alu_src ? w_ext_imm : w_rt_val;
    end

    // Pipeline register: rst > flush > stall > load; an invalid load is a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid  <= 1'b0;
            r_alu_ctl   <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rt_data   <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush || (!stall && !in_valid)) begin
            r_ex_valid  <= 1'b0;
            r_alu_ctl   <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_rt_data   <= '0;
            r_rd        <= '0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!stall) begin
            r_ex_valid  <= 1'b1;
            r_alu_ctl   <= w_alu_ctl;
            r_alu_a     <= w_rs_val;
            r_alu_b     <= w_alu_b;
            r_rt_data   <= w_rt_val;
            r_rd        <= rd_in;
            r_reg_write <= reg_write_in & ~w_illegal;
            r_illegal   <= w_illegal;
        end
    end

    assign ex_valid      = r_ex_valid;
    assign alu_ctl       = r_alu_ctl;
    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign rt_data_out   = r_rt_data;
    assign rd_out        = r_rd;
    assign reg_write_out = r_reg_write;
    assign illegal_funct = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage: directed cases plus
//                randomized traffic compared against a behavioural model.
//                Exercises forwarding when FORWARDING_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int W      = 32;
    localparam int REG_AW = 5;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              flush;
    logic              in_valid;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              alu_src;
    logic [W-1:0]      rs_data;
    logic [W-1:0]      rt_data;
    logic [15:0]       imm16;
    logic [REG_AW-1:0] rd_in;
    logic              reg_write_in;
    logic [REG_AW-1:0] rs_addr;
    logic [REG_AW-1:0] rt_addr;
    logic              exmem_we;
    logic [REG_AW-1:0] exmem_rd;
    logic [W-1:0]      exmem_data;
    logic              memwb_we;
    logic [REG_AW-1:0] memwb_rd;
    logic [W-1:0]      memwb_data;

    logic              ex_valid;
    logic [3:0]        alu_ctl;
    logic [W-1:0]      alu_a;
    logic [W-1:0]      alu_b;
    logic [W-1:0]      rt_data_out;
    logic [REG_AW-1:0] rd_out;
    logic              reg_write_out;
    logic              illegal_funct;

    // expected register contents
    logic              e_valid;
    logic [3:0]        e_ctl;
    logic [W-1:0]      e_a;
    logic [W-1:0]      e_b;
    logic [W-1:0]      e_rt;
    logic [REG_AW-1:0] e_rd;
    logic              e_rw;
    logic              e_ill;

    int n_total;
    int n_pass;

    // supported R-type functions and their ALU codes
    logic [5:0] fn_tab  [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [3:0] ctl_tab [5] = '{4'h2,  4'h6,  4'h0,  4'h1,  4'h7};

    id_ex_stage #(.W(W), .REG_AW(REG_AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .in_valid      (in_valid),
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_src       (alu_src),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .imm16         (imm16),
        .rd_in         (rd_in),
        .reg_write_in  (reg_write_in),
`ifdef FORWARDING_EN
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .exmem_we      (exmem_we),
        .exmem_rd      (exmem_rd),
        .exmem_data    (exmem_data),
        .memwb_we      (memwb_we),
        .memwb_rd      (memwb_rd),
        .memwb_data    (memwb_data),
`endif
        .ex_valid      (ex_valid),
        .alu_ctl       (alu_ctl),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .rt_data_out   (rt_data_out),
        .rd_out        (rd_out),
        .reg_write_out (reg_write_out),
        .illegal_funct (illegal_funct)
    );

    // free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".ex_valid"},      32'(ex_valid),      32'(e_valid));
        check({tag, ".alu_ctl"},       32'(alu_ctl),       32'(e_ctl));
        check({tag, ".alu_a"},         alu_a,              e_a);
        check({tag, ".alu_b"},         alu_b,              e_b);
        check({tag, ".rt_data_out"},   rt_data_out,        e_rt);
        check({tag, ".rd_out"},        32'(rd_out),        32'(e_rd));
        check({tag, ".reg_write_out"}, 32'(reg_write_out), 32'(e_rw));
        check({tag, ".illegal_funct"}, 32'(illegal_funct), 32'(e_ill));
    endtask

    task automatic model_clear();
        e_valid = 1'b0; e_ctl = '0; e_a = '0; e_b = '0;
        e_rt = '0; e_rd = '0; e_rw = 1'b0; e_ill = 1'b0;
    endtask

    // forwarded operand value for a given source register address
    function automatic logic [W-1:0] fwd(input logic [REG_AW-1:0] addr, input logic [W-1:0] regval);
        logic [W-1:0] v;
        v = regval;
`ifdef FORWARDING_EN
        if (exmem_we && exmem_rd != 0 && exmem_rd == addr)      v = exmem_data;
        else if (memwb_we && memwb_rd != 0 && memwb_rd == addr) v = memwb_data;
`else
        if (addr == 5'h1F && addr == 5'h00) v = '0;
`endif
        return v;
    endfunction

    // behavioural reference: what the stage should hold after the next edge
    task automatic model_step();
        logic [3:0]   ctl;
        logic         ill;
        logic [W-1:0] imm;
        logic [W-1:0] rsv;
        logic [W-1:0] rtv;
        if (flush || (!stall && !in_valid)) begin
            model_clear();
        end else if (!stall) begin
            ill = 1'b0;
            case (alu_op)
                2'd0: ctl = 4'd2;
                2'd1: ctl = 4'd6;
                2'd3: ctl = 4'd1;
                default: begin
                    ctl = 4'hF;
                    ill = 1'b1;
                    for (int k = 0; k < 5; k++) begin
                        if (fn_tab[k] == funct) begin
                            ctl = ctl_tab[k];
                            ill = 1'b0;
                        end
                    end
                end
            endcase
            if (alu_op == 2'd3) imm = W'(int'(imm16));
            else                imm = W'(int'($signed(imm16)));
            rsv = fwd(rs_addr, rs_data);
            rtv = fwd(rt_addr, rt_data);
            e_valid = 1'b1;
            e_ctl   = ctl;
            e_ill   = ill;
            e_a     = rsv;
            e_b     = alu_src ? imm : rtv;
            e_rt    = rtv;
            e_rd    = rd_in;
            e_rw    = reg_write_in && !ill;
        end
    endtask

    // apply model, clock once, sample 1 time unit after the edge
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] fn, input logic src,
                             input logic [W-1:0] rs, input logic [W-1:0] rt, input logic [15:0] imm,
                             input logic [REG_AW-1:0] rd, input logic rw);
        in_valid = 1'b1; alu_op = op; funct = fn; alu_src = src;
        rs_data = rs; rt_data = rt; imm16 = imm; rd_in = rd; reg_write_in = rw;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        set_instr(2'd0, 6'd0, 1'b0, '0, '0, 16'd0, '0, 1'b0);
        in_valid = 1'b0;
        rs_addr = '0; rt_addr = '0;
        exmem_we = 1'b0; exmem_rd = '0; exmem_data = '0;
        memwb_we = 1'b0; memwb_rd = '0; memwb_data = '0;
        model_clear();

        // reset state
        @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // R-type sub
        set_instr(2'b10, 6'h22, 1'b0, 32'd7, 32'd3, 16'h0000, 5'd9, 1'b1);
        tick("rtype_sub");

        // sign-extended immediate for add
        set_instr(2'b00, 6'h00, 1'b1, 32'h100, 32'h55, 16'hFFFC, 5'd4, 1'b1);
        tick("lw_signext");

        // zero-extended immediate for ori
        set_instr(2'b11, 6'h00, 1'b1, 32'h100, 32'h55, 16'hFFFC, 5'd4, 1'b1);
        tick("ori_zeroext");

        // load an add, then stall with different inputs: hold
        set_instr(2'b10, 6'h20, 1'b0, 32'h1234, 32'h4321, 16'h0001, 5'd12, 1'b1);
        tick("add_load");
        stall = 1'b1;
        set_instr(2'b01, 6'h2A, 1'b1, 32'hDEAD, 32'hBEEF, 16'h8000, 5'd30, 1'b0);
        tick("stall_hold");
        flush = 1'b1;
        tick("stall_flush");
        stall = 1'b0; flush = 1'b0;

        // unsupported R-type funct
        set_instr(2'b10, 6'h03, 1'b0, 32'd11, 32'd22, 16'h0000, 5'd7, 1'b1);
        tick("illegal_funct");

        // invalid instruction loads a bubble
        set_instr(2'b10, 6'h25, 1'b0, 32'd5, 32'd6, 16'h0000, 5'd8, 1'b1);
        tick("or_load");
        in_valid = 1'b0;
        tick("invalid_bubble");

        // asynchronous reset mid-run, between edges
        set_instr(2'b10, 6'h24, 1'b0, 32'hF0F0, 32'h0FF0, 16'h0000, 5'd3, 1'b1);
        tick("and_load");
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef FORWARDING_EN
        // EX/MEM has priority over MEM/WB
        set_instr(2'b00, 6'h00, 1'b0, 32'h11, 32'h22, 16'h0000, 5'd1, 1'b1);
        rs_addr = 5'd5; rt_addr = 5'd6;
        exmem_we = 1'b1; exmem_rd = 5'd5; exmem_data = 32'hAA;
        memwb_we = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hBB;
        tick("fwd_exmem");
        if (alu_a !== 32'hAA) begin
            n_total++;
            $error("FAIL fwd_direct: observed %h expected %h", alu_a, 32'hAA);
        end
        // register zero is never forwarded
        exmem_rd = 5'd0; memwb_rd = 5'd0; rs_addr = 5'd0;
        tick("fwd_r0");
        exmem_we = 1'b0; memwb_we = 1'b0;
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            alu_op   = 2'($urandom);
            funct    = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 4)];
            alu_src  = 1'($urandom);
            rs_data  = $urandom;
            rt_data  = $urandom;
            imm16    = 16'($urandom);
            rd_in    = 5'($urandom);
            reg_write_in = 1'($urandom);
`ifdef FORWARDING_EN
            rs_addr    = 5'($urandom_range(0, 3));
            rt_addr    = 5'($urandom_range(0, 3));
            exmem_we   = 1'($urandom);
            exmem_rd   = 5'($urandom_range(0, 3));
            exmem_data = $urandom;
            memwb_we   = 1'($urandom);
            memwb_rd   = 5'($urandom_range(0, 3));
            memwb_data = $urandom;
`endif
            tick("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
